// File: rtl/l2_cache.sv
// Direct-mapped, write-back, write-allocate L2 cache with line-granular L1 and memory ports.
// Hits respond in the cycle after IDLE sees them; misses write back a dirty victim, then fetch on reads.
module l2_cache #(
   parameter int INDEX_BITS = 6,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             proc_reset_n,
   input  logic             l1_read,
   input  logic             l1_write,
   input  logic [27:0]      l1_addr,
   input  logic [127:0]     l1_wdata,
   output logic [127:0]     l1_rdata,
   output logic             l1_ready,
   output logic             mem_read,
   output logic             mem_write,
   output logic [27:0]      mem_addr,
   output logic [127:0]     mem_wdata,
   input  logic [127:0]     mem_rdata,
   input  logic             mem_ready,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   localparam int NUM_OF_SET = 2 ** INDEX_BITS;
   localparam int TAG_W      = 28 - INDEX_BITS;

   typedef enum logic [1:0] {IDLE, WB, FETCH, RESP} state_e;

   state_e                  state_q;
   logic [127:0]            data_q [NUM_OF_SET];
   logic [TAG_W-1:0]        tag_q  [NUM_OF_SET];
   logic [NUM_OF_SET-1:0]   valid_q;
   logic [NUM_OF_SET-1:0]   dirty_q;
   logic [127:0]            l1Rdata_q;
   logic                    l1Ready_q;
   logic                    memRead_q;
   logic                    memWrite_q;
   logic [27:0]             memAddr_q;
   logic [127:0]            memWdata_q;
   logic [CNT_W-1:0]        hitCnt_q;
   logic [CNT_W-1:0]        missCnt_q;

   logic [INDEX_BITS-1:0]   idx;
   logic [TAG_W-1:0]        reqTag;
   logic                    reqValid;
   logic                    hit;
   logic                    victimDirty;
   logic                    dataWe;
   logic [127:0]            dataWdata;

   assign idx         = l1_addr[INDEX_BITS-1:0];
   assign reqTag      = l1_addr[27:INDEX_BITS];
   assign reqValid    = l1_read ^ l1_write;
   assign hit         = valid_q[idx] && (tag_q[idx] == reqTag);
   assign victimDirty = valid_q[idx] && dirty_q[idx];

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt);
      return (cnt == '1) ? cnt : cnt + 1'b1;
   endfunction

   // The line array has no reset; valid bits alone decide whether its contents mean anything.
   always_comb begin
      dataWe    = 1'b0;
      dataWdata = l1_wdata;
      case (state_q)
         IDLE:    dataWe = reqValid && l1_write && (hit || !victimDirty);
         WB:      dataWe = mem_ready && l1_write;
         FETCH: begin
            dataWe    = mem_ready;
            dataWdata = mem_rdata;
         end
         default: dataWe = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (dataWe) begin
         data_q[idx] <= dataWdata;
      end
   end

   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         state_q    <= IDLE;
         valid_q    <= '0;
         dirty_q    <= '0;
         for (int i = 0; i < NUM_OF_SET; i++) begin
            tag_q[i] <= '0;
         end
         l1Rdata_q  <= '0;
         l1Ready_q  <= 1'b0;
         memRead_q  <= 1'b0;
         memWrite_q <= 1'b0;
         memAddr_q  <= '0;
         memWdata_q <= '0;
         hitCnt_q   <= '0;
         missCnt_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (reqValid) begin
                  if (hit) begin
                     hitCnt_q  <= satInc(hitCnt_q);
                     if (l1_read) begin
                        l1Rdata_q <= data_q[idx];
                     end else begin
                        dirty_q[idx] <= 1'b1;
                     end
                     l1Ready_q <= 1'b1;
                     state_q   <= RESP;
                  end else begin
                     missCnt_q <= satInc(missCnt_q);
                     if (victimDirty) begin
                        memWrite_q <= 1'b1;
                        memAddr_q  <= {tag_q[idx], idx};
                        memWdata_q <= data_q[idx];
                        state_q    <= WB;
                     end else if (l1_read) begin
                        memRead_q <= 1'b1;
                        memAddr_q <= l1_addr;
                        state_q   <= FETCH;
                     end else begin
                        // A full-line write needs no fetch before allocating.
                        tag_q[idx]   <= reqTag;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b1;
                        l1Ready_q    <= 1'b1;
                        state_q      <= RESP;
                     end
                  end
               end
            end
            WB: begin
               if (mem_ready) begin
                  memWrite_q   <= 1'b0;
                  dirty_q[idx] <= 1'b0;
                  if (l1_read) begin
                     memRead_q <= 1'b1;
                     memAddr_q <= l1_addr;
                     state_q   <= FETCH;
                  end else begin
                     tag_q[idx]   <= reqTag;
                     valid_q[idx] <= 1'b1;
                     dirty_q[idx] <= 1'b1;
                     l1Ready_q    <= 1'b1;
                     state_q      <= RESP;
                  end
               end
            end
            FETCH: begin
               if (mem_ready) begin
                  memRead_q    <= 1'b0;
                  tag_q[idx]   <= reqTag;
                  valid_q[idx] <= 1'b1;
                  dirty_q[idx] <= 1'b0;
                  l1Rdata_q    <= mem_rdata;
                  l1Ready_q    <= 1'b1;
                  state_q      <= RESP;
               end
            end
            RESP: begin
               l1Ready_q <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign l1_rdata  = l1Rdata_q;
   assign l1_ready  = l1Ready_q;
   assign mem_read  = memRead_q;
   assign mem_write = memWrite_q;
   assign mem_addr  = memAddr_q;
   assign mem_wdata = memWdata_q;
   assign hit_cnt   = hitCnt_q;
   assign miss_cnt  = missCnt_q;

endmodule
